// File: rtl/id_ex_reg_if.sv
// D/E pipeline bus: decode-stage inputs, write-back bypass source and the
// registered execute-stage outputs of the ID/EX register.
interface id_ex_reg_if;
  logic [31:0] pc_D;
  logic [31:0] instr_D;
  logic [31:0] rs_data_D;
  logic [31:0] rt_data_D;
  logic [31:0] imm32_D;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic [31:0] pc_E;
  logic [31:0] pc8_E;
  logic [31:0] instr_E;
  logic [31:0] rs_data_E;
  logic [31:0] rt_data_E;
  logic [31:0] imm32_E;
  logic        valid_E;

  // master: the surrounding pipeline (drives D/W side, consumes E side)
  modport master (
    output pc_D, instr_D, rs_data_D, rt_data_D, imm32_D,
    output wb_we, wb_addr, wb_data,
    input  pc_E, pc8_E, instr_E, rs_data_E, rt_data_E, imm32_E, valid_E
  );

  // slave: the ID/EX register itself
  modport slave (
    input  pc_D, instr_D, rs_data_D, rt_data_D, imm32_D,
    input  wb_we, wb_addr, wb_data,
    output pc_E, pc8_E, instr_E, rs_data_E, rt_data_E, imm32_E, valid_E
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with bubble insertion, flush, freeze and
// write-back bypass on capture. Every output is driven straight from a flop.
module id_ex_reg #(
  parameter logic [31:0] PC_RESET   = 32'h0000_3000,
  parameter bit          ZERO_GUARD = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        stall,
  input  logic        freeze,
  id_ex_reg_if.slave  bus
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc8_q, pc8_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] rs_data_q, rs_data_d;
  logic [31:0] rt_data_q, rt_data_d;
  logic [31:0] imm32_q, imm32_d;
  logic        valid_q, valid_d;

  logic [4:0]  rs_addr, rt_addr;
  logic        wb_ok;
  logic        rs_hit, rt_hit;

  assign rs_addr = bus.instr_D[25:21];
  assign rt_addr = bus.instr_D[20:16];

  // A W-stage write to $0 is discarded by the GRF, so it must not be forwarded
  // unless the guard is disabled.
  assign wb_ok  = bus.wb_we && ((ZERO_GUARD == 1'b0) || (bus.wb_addr != 5'd0));
  assign rs_hit = wb_ok && (bus.wb_addr == rs_addr);
  assign rt_hit = wb_ok && (bus.wb_addr == rt_addr);

  // Next-state selection: flush > freeze > stall > load (reset handled in the flop).
  always_comb begin
    pc_d      = pc_q;
    pc8_d     = pc8_q;
    instr_d   = instr_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm32_d   = imm32_q;
    valid_d   = valid_q;
    if (flush) begin
      pc_d      = PC_RESET;
      pc8_d     = PC_RESET + 32'd8;
      instr_d   = 32'h0;
      rs_data_d = 32'h0;
      rt_data_d = 32'h0;
      imm32_d   = 32'h0;
      valid_d   = 1'b0;
    end else if (freeze) begin
      // hold everything
    end else if (stall) begin
      // bubble keeps the stalled instruction's PC for exception/debug use
      pc_d      = bus.pc_D;
      pc8_d     = bus.pc_D + 32'd8;
      instr_d   = 32'h0;
      rs_data_d = 32'h0;
      rt_data_d = 32'h0;
      imm32_d   = 32'h0;
      valid_d   = 1'b0;
    end else begin
      pc_d      = bus.pc_D;
      pc8_d     = bus.pc_D + 32'd8;
      instr_d   = bus.instr_D;
      rs_data_d = rs_hit ? bus.wb_data : bus.rs_data_D;
      rt_data_d = rt_hit ? bus.wb_data : bus.rt_data_D;
      imm32_d   = bus.imm32_D;
      valid_d   = 1'b1;
    end
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= PC_RESET;
      pc8_q     <= PC_RESET + 32'd8;
      instr_q   <= 32'h0;
      rs_data_q <= 32'h0;
      rt_data_q <= 32'h0;
      imm32_q   <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pc8_q     <= pc8_d;
      instr_q   <= instr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm32_q   <= imm32_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.pc_E      = pc_q;
  assign bus.pc8_E     = pc8_q;
  assign bus.instr_E   = instr_q;
  assign bus.rs_data_E = rs_data_q;
  assign bus.rt_data_E = rt_data_q;
  assign bus.imm32_E   = imm32_q;
  assign bus.valid_E   = valid_q;

endmodule

// File: doc/id_ex_reg.md
Name: id_ex_reg

Overview:
- Pipeline register between the decode (D) stage and the execute (E) stage of the five-stage MIPS core.
- Captures the D-stage PC, instruction, the two GRF read values and the 32-bit extended immediate, and presents them to E one cycle later.
- Implements bubble insertion (stall), flush, whole-pipe freeze and write-back bypass on capture.
- Also produces the registered link address for jal/jalr.

Parameters:
PC_RESET, 32'h0000_3000, value of pc_E after reset and after flush
ZERO_GUARD, 1, when 1 a bypass is never taken for register $0

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  discard the E-stage contents (branch/jump redirect)
stall  input  1  D stage is stalled by the hazard unit; E receives a bubble
freeze  input  1  whole pipeline held (E keeps its contents)
pc_D  input  32  PC of the instruction in D
instr_D  input  32  instruction word in D
rs_data_D  input  32  GRF read data for instr_D[25:21]
rt_data_D  input  32  GRF read data for instr_D[20:16]
imm32_D  input  32  extended immediate from the D-stage extender
wb_we  input  1  W-stage GRF write enable
wb_addr  input  5  W-stage destination register
wb_data  input  32  W-stage write data
pc_E  output  32  registered PC
pc8_E  output  32  registered pc_D + 8 (link address)
instr_E  output  32  registered instruction; 32'h0 is a bubble (nop)
rs_data_E  output  32  registered rs operand
rt_data_E  output  32  registered rt operand
imm32_E  output  32  registered immediate
valid_E  output  1  1 when E holds a real instruction, 0 for a bubble

Behaviour:
- Update priority at each rising edge: reset > flush > freeze > stall > load.
- reset:
  - pc_E = PC_RESET, pc8_E = PC_RESET + 8.
  - instr_E, rs_data_E, rt_data_E and imm32_E = 0.
  - valid_E = 0.
- flush: same values as reset. Takes effect even when stall or freeze is also asserted.
- freeze (no reset/flush): every output register holds its value. This applies even when stall is also asserted.
- stall (no reset/flush/freeze): inserts a bubble.
  - instr_E, rs_data_E, rt_data_E, imm32_E = 0; valid_E = 0.
  - pc_E = pc_D and pc8_E = pc_D + 8, so the bubble carries the stalled instruction's PC for later exception/debug use.
- load (no control asserted):
  - pc_E = pc_D; pc8_E = pc_D + 8, with modulo-2^32 wrap (pc_D = 32'hFFFF_FFFC gives 32'h0000_0004).
  - instr_E = instr_D; imm32_E = imm32_D; valid_E = 1.
- Write-back bypass on capture, applied only in load:
  - rs_data_E = wb_data if wb_we = 1, wb_addr == instr_D[25:21], and (ZERO_GUARD = 0 or wb_addr != 0); otherwise rs_data_E = rs_data_D.
  - rt_data_E uses the same rule against instr_D[20:16].
  - rs and rt may both bypass in the same cycle when both fields equal wb_addr.
- Latency: exactly one cycle from D inputs to E outputs. No combinational path from any input to any output; all outputs come directly from flops.
- Reset during a stall or freeze: reset wins; the next cycle resumes normal loading if no control is asserted.
- No initial blocks. Power-up state is defined only by reset.

Test Plan:
- Reset: assert reset 1 cycle with random inputs -> pc_E = 32'h3000, pc8_E = 32'h3008, instr_E = 0, valid_E = 0, all data outputs 0.
- Plain load: pc_D = 32'h3004, instr_D = 32'h2408_FFFF, imm32_D = 32'hFFFF_FFFF, rs = 32'h11, rt = 32'h22 -> next cycle outputs equal the inputs, pc8_E = 32'h300C, valid_E = 1.
- Stall then release:
  - stall = 1 with pc_D = 32'h3010 -> instr_E = 0, valid_E = 0, pc_E = 32'h3010.
  - stall = 0 the following cycle -> D values captured and valid_E = 1.
- Freeze and flush priority:
  - After a load, freeze = 1 and stall = 1 for 3 cycles with changing inputs -> outputs unchanged.
  - freeze = 1 and flush = 1 -> reset values.
- Bypass:
  - instr_D rs = rt = 5'd8, wb_we = 1, wb_addr = 8, wb_data = 32'hDEAD_BEEF -> rs_data_E = rt_data_E = 32'hDEAD_BEEF.
  - wb_addr = 0 with instr rs = 0 -> rs_data_D used.
  - wb_we = 0 -> rs_data_D used.
- Wrap: pc_D = 32'hFFFF_FFFC -> pc8_E = 32'h0000_0004.
